hazard_controller: RTL and testbench

//  Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
//  - Emits stall, flush and forwarding controls from decoded control bits and register addresses.
//  - Resolves load-use hazards, taken branches/jumps (resolved in EX), and multi-cycle mulp/divp occupancy of the EX stage.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/forwarding_unit.sv | 25 ++
 rtl/hazard_controller.sv | 157 +++++++++++++++
 tb/tb_hazard_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared opcode/funct2 encodings, forwarding selects and hazard FSM states
// for the 5-stage core.
package pipeline_pkg;

  localparam logic [2:0] OP_ARITH  = 3'b000;
  localparam logic [2:0] OP_LOGIC  = 3'b001;
  localparam logic [2:0] OP_IMM    = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_STORE  = 3'b100;
  localparam logic [2:0] OP_BRANCH = 3'b101;

  localparam logic [1:0] F2_MUL = 2'b10;
  localparam logic [1:0] F2_DIV = 2'b11;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    MD_BUSY,
    MD_DONE
  } hz_state_e;

  function automatic logic is_muldiv(input logic [2:0] opcode, input logic [1:0] funct2);
    return (opcode == OP_ARITH) && ((funct2 == F2_MUL) || (funct2 == F2_DIV));
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Operand bypass select for one EX source register; the younger EX/MEM
// result wins over MEM/WB, and r0 is never forwarded.
module forwarding_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output fwd_sel_e              sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencer for the 5-stage pipeline.
// Define HAZARD_PERF_EN to add the perf_stall_cycles/perf_flushes counters.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic [2:0]            ex_opcode,
  input  logic [1:0]            ex_funct2,
  input  logic                  ex_br_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  stall_idex,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flushes
`endif
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_LAT > 1) ? CNT_W'(DIV_LAT - 2) : '0;
  localparam logic MUL_MULTI = (MUL_LAT > 1);
  localparam logic DIV_MULTI = (DIV_LAT > 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fwd_sel_e         sel_a, sel_b;
  logic             load_use, br_flush, md_start, is_mul;

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_a)
  );

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_b)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    fwd_a       = rst ? 2'b00 : sel_a;
    fwd_b       = rst ? 2'b00 : sel_b;

    is_mul   = (ex_funct2 == F2_MUL);
    md_start = ex_valid && is_muldiv(ex_opcode, ex_funct2) && (state_q == RUN) &&
               (is_mul ? MUL_MULTI : DIV_MULTI);
    load_use = ex_valid && ex_memread && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    br_flush = ex_br_taken && (state_q != MD_BUSY);

    case (state_q)
      RUN: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = is_mul ? MUL_LOAD : DIV_LOAD;
        end
      end
      MD_BUSY: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        flush_exmem = 1'b1;
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DONE: state_d = RUN;
      default: state_d = RUN;
    endcase

    // A taken branch squashes the ID instruction, so its load-use stall is moot.
    if (br_flush) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (load_use && (state_q != MD_BUSY)) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end

    if (rst) begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
    end
  end

  assign md_busy = (state_q == MD_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_pc};
    perf_flush_d = perf_flush_q + {31'd0, (flush_ifid && !rst)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (REG_ADDR_W=4, MUL_LAT=2, DIV_LAT=8).
// Builds with or without HAZARD_PERF_EN.
module tb_hazard_controller;

  logic       clk, rst;
  logic [3:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs2, ex_valid, ex_memread, ex_br_taken, mem_regwrite, wb_regwrite;
  logic [2:0] ex_opcode;
  logic [1:0] ex_funct2;
  logic       stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem, md_busy;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  int checks = 0;
  int passed = 0;

  hazard_controller #(.REG_ADDR_W(4), .MUL_LAT(2), .DIV_LAT(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_opcode(ex_opcode), .ex_funct2(ex_funct2),
    .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_rd = 0; ex_memread = 0; ex_opcode = 3'b000; ex_funct2 = 2'b00; ex_br_taken = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    mem_regwrite = 1; mem_rd = 3; ex_rs1 = 3;
    ex_valid = 1; ex_memread = 1; ex_opcode = 3'b011; ex_rd = 5; id_rs1 = 5;
    tick(); tick();
    checks++; if (fwd_a !== 2'b00) $display("[TB] FAIL reset_fwd_a: got %b want 00", fwd_a); else passed++;
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL reset_stall_pc: got %b want 0", stall_pc); else passed++;
    checks++; if (flush_idex !== 1'b0) $display("[TB] FAIL reset_flush_idex: got %b want 0", flush_idex); else passed++;
    checks++; if (md_busy !== 1'b0) $display("[TB] FAIL reset_md_busy: got %b want 0", md_busy); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (fwd_a !== 2'b10) $display("[TB] FAIL post_reset_fwd_a: got %b want 10", fwd_a); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_forwarding();
    mem_regwrite = 1; mem_rd = 3; wb_regwrite = 1; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 7;
    #1;
    checks++; if (fwd_a !== 2'b10) $display("[TB] FAIL fwd_a_mem_prio: got %b want 10", fwd_a); else passed++;
    checks++; if (fwd_b !== 2'b00) $display("[TB] FAIL fwd_b_nomatch: got %b want 00", fwd_b); else passed++;
    mem_rd = 0;
    #1;
    checks++; if (fwd_a !== 2'b01) $display("[TB] FAIL fwd_a_memrd0: got %b want 01", fwd_a); else passed++;
    mem_rd = 7; ex_rs2 = 7;
    #1;
    checks++; if (fwd_b !== 2'b10) $display("[TB] FAIL fwd_b_mem: got %b want 10", fwd_b); else passed++;
    mem_regwrite = 0; wb_rd = 7;
    #1;
    checks++; if (fwd_b !== 2'b01) $display("[TB] FAIL fwd_b_wb: got %b want 01", fwd_b); else passed++;
    wb_rd = 0; ex_rs2 = 0;
    #1;
    checks++; if (fwd_b !== 2'b00) $display("[TB] FAIL fwd_b_r0: got %b want 00", fwd_b); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    ex_valid = 1; ex_memread = 1; ex_opcode = 3'b011; ex_rd = 5;
    id_rs1 = 1; id_rs2 = 5; id_uses_rs2 = 1;
    #1;
    checks++; if (stall_pc !== 1'b1) $display("[TB] FAIL lu_stall_pc: got %b want 1", stall_pc); else passed++;
    checks++; if (stall_ifid !== 1'b1) $display("[TB] FAIL lu_stall_ifid: got %b want 1", stall_ifid); else passed++;
    checks++; if (flush_idex !== 1'b1) $display("[TB] FAIL lu_flush_idex: got %b want 1", flush_idex); else passed++;
    checks++; if (stall_idex !== 1'b0) $display("[TB] FAIL lu_stall_idex: got %b want 0", stall_idex); else passed++;
    tick();
    ex_valid = 0;
    #1;
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL lu_bubble_stall_pc: got %b want 0", stall_pc); else passed++;
    ex_valid = 1; id_uses_rs2 = 0;
    #1;
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL lu_no_rs2_stall_pc: got %b want 0", stall_pc); else passed++;
    ex_rd = 0; id_rs1 = 0;
    #1;
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL lu_r0_stall_pc: got %b want 0", stall_pc); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_divp();
    ex_valid = 1; ex_opcode = 3'b000; ex_funct2 = 2'b11;
    #1;
    checks++; if (md_busy !== 1'b0) $display("[TB] FAIL div_issue_md_busy: got %b want 0", md_busy); else passed++;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (md_busy !== 1'b1) $display("[TB] FAIL div_busy_%0d: got %b want 1", i, md_busy); else passed++;
      checks++; if (flush_exmem !== 1'b1) $display("[TB] FAIL div_flush_exmem_%0d: got %b want 1", i, flush_exmem); else passed++;
      checks++; if (stall_idex !== 1'b1) $display("[TB] FAIL div_stall_idex_%0d: got %b want 1", i, stall_idex); else passed++;
      if (i == 3) begin
        ex_br_taken = 1;
        #1;
        checks++; if (flush_ifid !== 1'b0) $display("[TB] FAIL div_branch_ignored: got %b want 0", flush_ifid); else passed++;
        ex_br_taken = 0;
      end
    end
    tick();
    checks++; if (md_busy !== 1'b0) $display("[TB] FAIL div_done_md_busy: got %b want 0", md_busy); else passed++;
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL div_done_stall_pc: got %b want 0", stall_pc); else passed++;
    checks++; if (flush_exmem !== 1'b0) $display("[TB] FAIL div_done_flush_exmem: got %b want 0", flush_exmem); else passed++;
    tick();
    ex_valid = 0;
    #1;
    checks++; if (md_busy !== 1'b0) $display("[TB] FAIL div_no_retrigger: got %b want 0", md_busy); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_vs_load_use();
    ex_valid = 1; ex_memread = 1; ex_opcode = 3'b011; ex_rd = 5; id_rs1 = 5; ex_br_taken = 1;
    #1;
    checks++; if (flush_ifid !== 1'b1) $display("[TB] FAIL br_flush_ifid: got %b want 1", flush_ifid); else passed++;
    checks++; if (flush_idex !== 1'b1) $display("[TB] FAIL br_flush_idex: got %b want 1", flush_idex); else passed++;
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL br_stall_pc: got %b want 0", stall_pc); else passed++;
    checks++; if (stall_ifid !== 1'b0) $display("[TB] FAIL br_stall_ifid: got %b want 0", stall_ifid); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    ex_valid = 1; ex_opcode = 3'b000; ex_funct2 = 2'b11;
    tick(); tick(); tick();
    checks++; if (md_busy !== 1'b1) $display("[TB] FAIL rmb_busy_before: got %b want 1", md_busy); else passed++;
    rst = 1;
    #1;
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL rmb_stall_in_rst: got %b want 0", stall_pc); else passed++;
    tick();
    rst = 0;
    clear_inputs();
    #1;
    checks++; if (md_busy !== 1'b0) $display("[TB] FAIL rmb_md_busy: got %b want 0", md_busy); else passed++;
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL rmb_stall_pc: got %b want 0", stall_pc); else passed++;
    checks++; if (flush_exmem !== 1'b0) $display("[TB] FAIL rmb_flush_exmem: got %b want 0", flush_exmem); else passed++;
    ex_valid = 1; ex_opcode = 3'b000; ex_funct2 = 2'b10;
    tick();
    checks++; if (stall_pc !== 1'b1) $display("[TB] FAIL mul_stall_1: got %b want 1", stall_pc); else passed++;
    tick();
    checks++; if (stall_pc !== 1'b0) $display("[TB] FAIL mul_stall_2: got %b want 0", stall_pc); else passed++;
    checks++; if (md_busy !== 1'b0) $display("[TB] FAIL mul_done_md_busy: got %b want 0", md_busy); else passed++;
    tick();
    clear_inputs();
    tick();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst = 1;
    tick();
    rst = 0;
    ex_valid = 1; ex_opcode = 3'b000; ex_funct2 = 2'b10;
    tick();
    tick();
    ex_valid = 0;
    tick();
    ex_br_taken = 1;
    tick();
    ex_br_taken = 0;
    #1;
    checks++; if (perf_stall_cycles !== 32'd1) $display("[TB] FAIL perf_stall_cycles: got %0d want 1", perf_stall_cycles); else passed++;
    checks++; if (perf_flushes !== 32'd1) $display("[TB] FAIL perf_flushes: got %0d want 1", perf_flushes); else passed++;
    clear_inputs();
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_divp();
    test_branch_vs_load_use();
    test_reset_mid_busy();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
